regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Command-driven initiator for the 8x16 register file: accepts one command per valid/ready
//  handshake and drives the file's write port (writenum/write/data_in) and its read port
//  (readnum, with the file's combinational data_out returned).
//  Sits between the instruction/test front end and the register file, and sequences the
//  multi-cycle read-then-write accesses needed by the file's single read port.
// PARAMETERS
//  N     16  data width; equals register width
//  AW     3  register index width (2**AW = 8 registers)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  cmd_valid     in   1   command offered
//  cmd_ready     out  1   sequencer can accept (IDLE only)
//  cmd_op        in   2   00 LDI, 01 MOV, 10 ADD, 11 RD
//  cmd_rd        in   AW  destination register
//  cmd_rs        in   AW  source register
//  cmd_imm       in   N   immediate for LDI
//  rf_writenum   out  AW  to regfile writenum
//  rf_write      out  1   to regfile write enable
//  rf_data_in    out  N   to regfile data_in
//  rf_readnum    out  AW  to regfile readnum
//  rf_data_out   in   N   from regfile data_out (combinational w.r.t. rf_readnum)
//  done          out  1   one-cycle pulse, command complete
//  rsp_data      out  N   result of last command (value written, or value read for RD)
//  carry         out  1   carry-out of last ADD; cleared by LDI/MOV; unchanged by RD
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; cmd_ready=1 once released; rf_write=0; done=0;
//   rsp_data=0; carry=0; rf_writenum=rf_readnum=0; rf_data_in=0. Register contents untouched.
//  Command acceptance: handshake on the rising edge where cmd_valid & cmd_ready.
//   op/rd/rs/imm are latched on that edge; inputs are ignored while busy.
//  States: IDLE, RD_S, RD_D, WR, DONE.
//   IDLE: cmd_ready=1. On accept: LDI->WR (result=imm); MOV/ADD/RD->RD_S.
//   RD_S: rf_readnum=rs; a<=rf_data_out at the edge. MOV->WR (result=a); ADD->RD_D; RD->DONE.
//   RD_D: rf_readnum=rd; {carry_n,result}<=a+rf_data_out (N+1-bit sum, wraps mod 2**N); ->WR.
//   WR: rf_write=1, rf_writenum=rd, rf_data_in=result for exactly this one cycle; the file
//    captures at the closing edge; ->DONE.
//   DONE: done=1 for one cycle; rsp_data/carry valid from this cycle until the next DONE; ->IDLE.
//  Latency, accept edge to done cycle: LDI 2, MOV 3, RD 2, ADD 4. cmd_ready is low in all
//   non-IDLE states, so back-to-back commands have a one-cycle IDLE gap.
//  rf_write, cmd_ready and done decode from registered state only (glitch-free, no comb
//   path from cmd_* to rf_*). rf_readnum outside RD_S/RD_D holds its last value.
//  Hazards: the write lands before DONE, so any later command reading rd sees the new value.
//   rd==rs is legal: ADD R3,R3 doubles R3; MOV R3,R3 rewrites the same value.
//  Reset mid-command: abort immediately; rf_write drops asynchronously with state; no
//   partial write; done is not pulsed.
//  RD never asserts rf_write.
// STRUCTURE
//  Package regfile_pkg: N, AW, NREG; op encodings OP_LDI/OP_MOV/OP_ADD/OP_RD; state encodings.
//   The register file and this block share the package.
//  No sub-module; a single FSM plus a datapath (a, result, carry registers) in one module.
//  The bench instantiates regfile_sequencer together with the real register file.
// TESTING
//  1 Reset: rst_n=0 mid-WR of LDI R2,0x1234 -> rf_write=0 at once; later RD R2 returns old value; done not pulsed.
//  2 LDI R1,0x00FF then RD R1 -> rf_write=1 in one cycle with writenum=1, data_in=0x00FF; RD done 2 cycles after accept, rsp_data=0x00FF.
//  3 LDI R0,0xFFFF; LDI R5,0x0001; ADD R5,R0 -> R5=0x0000, carry=1, rsp_data=0x0000, done 4 cycles after accept.
//  4 LDI R3,0x4000; ADD R3,R3 -> R3=0x8000, carry=0; MOV R7,R3 -> R7=0x8000, carry=0.
//  5 cmd_valid held high with 3 queued commands -> cmd_ready only in IDLE; exactly 3 done pulses; no command lost or duplicated.
//  6 Random 2000-command run vs. a reference model of 8 registers -> every rsp_data, carry and final register contents match.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
//  regfile_pkg : shared widths, opcodes and sequencer state encoding for the
//                8x16 register file and its command sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int N    = 16;
  localparam int AW   = 3;
  localparam int NREG = 1 << AW;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_S = 3'd1,
    S_RD_D = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
//  regfile : 8x16 register file, one synchronous write port and one
//            combinational read port. Contents are not reset.
//  Rev 1.0
// ============================================================================
`default_nettype none

module regfile
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic [N-1:0]  data_in_i,
  input  logic [AW-1:0] writenum_i,
  input  logic          write_i,
  input  logic [AW-1:0] readnum_i,
  output logic [N-1:0]  data_out_o
);

  logic [N-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (write_i) begin
      regs_q[writenum_i] <= data_in_i;
    end
  end

  assign data_out_o = regs_q[readnum_i];

endmodule

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
//  regfile_sequencer : command-driven initiator for the register file; turns
//                      LDI/MOV/ADD/RD commands into read/write port sequences.
//  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_sequencer
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [N-1:0]  cmd_imm,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [N-1:0]  rf_data_in,
  output logic [AW-1:0] rf_readnum,
  input  logic [N-1:0]  rf_data_out,
  output logic          done,
  output logic [N-1:0]  rsp_data,
  output logic          carry
);

  state_e        state_q,   state_d;
  logic [1:0]    op_q,      op_d;
  logic [AW-1:0] rd_q,      rd_d;
  logic [AW-1:0] readnum_q, readnum_d;
  logic [N-1:0]  a_q,       a_d;
  logic [N-1:0]  result_q,  result_d;
  logic          cnext_q,   cnext_d;
  logic [N-1:0]  rsp_q,     rsp_d;
  logic          carry_q,   carry_d;

  logic          accept;
  logic [N:0]    sum;

  assign accept = cmd_valid && (state_q == S_IDLE);
  assign sum    = {1'b0, a_q} + {1'b0, rf_data_out};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    readnum_d = readnum_q;
    a_d       = a_q;
    result_d  = result_q;
    cnext_d   = cnext_q;
    rsp_d     = rsp_q;
    carry_d   = carry_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = cmd_op;
          rd_d = cmd_rd;
          if (cmd_op == OP_LDI) begin
            result_d = cmd_imm;
            cnext_d  = 1'b0;
            state_d  = S_WR;
          end else begin
            // Read port is registered so rf_* never sees a comb path from cmd_*.
            readnum_d = cmd_rs;
            state_d   = S_RD_S;
          end
        end
      end
      S_RD_S: begin
        a_d = rf_data_out;
        case (op_q)
          OP_MOV: begin
            result_d = rf_data_out;
            cnext_d  = 1'b0;
            state_d  = S_WR;
          end
          OP_ADD: begin
            readnum_d = rd_q;
            state_d   = S_RD_D;
          end
          default: begin
            rsp_d   = rf_data_out;
            state_d = S_DONE;
          end
        endcase
      end
      S_RD_D: begin
        {cnext_d, result_d} = sum;
        state_d             = S_WR;
      end
      S_WR: begin
        // Result and carry are published together on entry to DONE.
        rsp_d   = result_q;
        carry_d = cnext_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LDI;
      rd_q      <= '0;
      readnum_q <= '0;
      a_q       <= '0;
      result_q  <= '0;
      cnext_q   <= 1'b0;
      rsp_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      readnum_q <= readnum_d;
      a_q       <= a_d;
      result_q  <= result_d;
      cnext_q   <= cnext_d;
      rsp_q     <= rsp_d;
      carry_q   <= carry_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign rf_write    = (state_q == S_WR);
  assign done        = (state_q == S_DONE);
  assign rf_writenum = rd_q;
  assign rf_data_in  = result_q;
  assign rf_readnum  = readnum_q;
  assign rsp_data    = rsp_q;
  assign carry       = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
//  tb_regfile_sequencer : sequencer plus real register file against an
//                         architectural model of eight registers and a carry.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_rd = 3'd0;
  logic [2:0]  cmd_rs = 3'd0;
  logic [15:0] cmd_imm = 16'h0;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;
  logic        done;
  logic [15:0] rsp_data;
  logic        carry;

  regfile_sequencer u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs      (cmd_rs),
    .cmd_imm     (cmd_imm),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .rf_readnum  (rf_readnum),
    .rf_data_out (rf_data_out),
    .done        (done),
    .rsp_data    (rsp_data),
    .carry       (carry)
  );

  regfile u_rf (
    .clk        (clk),
    .data_in_i  (rf_data_in),
    .writenum_i (rf_writenum),
    .write_i    (rf_write),
    .readnum_i  (rf_readnum),
    .data_out_o (rf_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  wnum;
    logic [15:0] rsp;
    logic        c;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_rf [8];
  logic        m_c = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  bit          cmp_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input logic [1:0] op);
    case (op)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 4;
      default: return 2;
    endcase
  endfunction

  // Architectural effect of one command, applied at its accept edge.
  task automatic model_apply(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [15:0] imm, input int acc);
    exp_t        e;
    logic [16:0] s;
    case (op)
      2'b00: begin m_rf[rd] = imm; e.rsp = imm; m_c = 1'b0; end
      2'b01: begin e.rsp = m_rf[rs]; m_rf[rd] = e.rsp; m_c = 1'b0; end
      2'b10: begin
        s = {1'b0, m_rf[rd]} + {1'b0, m_rf[rs]};
        m_rf[rd] = s[15:0]; m_c = s[16]; e.rsp = s[15:0];
      end
      default: e.rsp = m_rf[rs];
    endcase
    e.op = op; e.wnum = rd; e.c = m_c; e.acc = acc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() == 0));
      if (rf_write) begin
        if (q.size() == 0) chk("write_when_idle", 32'(rf_write), 32'd0);
        else begin
          chk("write_op_not_rd", 32'(q[0].op == 2'b11), 32'd0);
          chk("writenum", 32'(rf_writenum), 32'(q[0].wnum));
          chk("data_in", 32'(rf_data_in), 32'(q[0].rsp));
        end
      end
      if (done) begin
        done_cnt++;
        if (q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.rsp));
          chk("carry", 32'(carry), 32'(e.c));
          chk("latency", 32'(cyc - e.acc), 32'(lat(e.op)));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [15:0] imm, input bit hold);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    model_apply(op, rd, rs, imm, cyc);
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("done_wait", 32'(q.size()), 32'd0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    logic [1:0] op;

    repeat (3) @(negedge clk);
    chk("reset_rsp", 32'(rsp_data), 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);
    chk("reset_write", 32'(rf_write), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_writenum", 32'(rf_writenum), 32'd0);
    chk("reset_readnum", 32'(rf_readnum), 32'd0);
    chk("reset_data_in", 32'(rf_data_in), 32'd0);
    rst_n = 1'b1;

    // Reset abort in the middle of a write
    send(2'b00, 3'd2, 3'd0, 16'h1111, 1'b0);
    wait_done();
    cmp_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd2; cmd_imm = 16'h1234;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_write_before_reset", 32'(rf_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_write_async_drop", 32'(rf_write), 32'd0);
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_rsp_cleared", 32'(rsp_data), 32'd0);
    m_c = 1'b0;
    @(negedge clk);
    chk("t1_done_low_2", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    send(2'b11, 3'd0, 3'd2, 16'h0, 1'b0);
    wait_done();
    chk("t1_old_value", 32'(rsp_data), 32'h1111);

    // LDI then RD
    send(2'b00, 3'd1, 3'd0, 16'h00FF, 1'b0);
    send(2'b11, 3'd0, 3'd1, 16'h0, 1'b0);
    wait_done();
    chk("t2_rd_rsp", 32'(rsp_data), 32'h00FF);

    // ADD wrap with carry
    send(2'b00, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    send(2'b00, 3'd5, 3'd0, 16'h0001, 1'b0);
    send(2'b10, 3'd5, 3'd0, 16'h0, 1'b0);
    wait_done();
    chk("t3_add_rsp", 32'(rsp_data), 32'h0000);
    chk("t3_add_carry", 32'(carry), 32'd1);
    chk("t3_r5", 32'(u_rf.regs_q[5]), 32'h0000);

    // rd==rs doubling, then MOV clears carry
    send(2'b00, 3'd3, 3'd0, 16'h4000, 1'b0);
    send(2'b10, 3'd3, 3'd3, 16'h0, 1'b0);
    wait_done();
    chk("t4_add_rsp", 32'(rsp_data), 32'h8000);
    chk("t4_add_carry", 32'(carry), 32'd0);
    send(2'b01, 3'd7, 3'd3, 16'h0, 1'b0);
    wait_done();
    chk("t4_mov_rsp", 32'(rsp_data), 32'h8000);
    chk("t4_r7", 32'(u_rf.regs_q[7]), 32'h8000);

    // Three commands with cmd_valid held high throughout
    d0 = done_cnt;
    send(2'b00, 3'd4, 3'd0, 16'hABCD, 1'b1);
    send(2'b01, 3'd6, 3'd4, 16'h0, 1'b1);
    send(2'b10, 3'd6, 3'd4, 16'h0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("t5_done_count", 32'(done_cnt - d0), 32'd3);
    chk("t5_rsp", 32'(rsp_data), 32'h579A);
    chk("t5_carry", 32'(carry), 32'd1);

    // Random run
    for (int i = 0; i < 8; i++) send(2'b00, 3'(i), 3'd0, 16'($urandom), 1'b0);
    for (int i = 0; i < 2000; i++) begin
      op = 2'($urandom_range(0, 3));
      send(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
    end
    wait_done();
    for (int i = 0; i < 8; i++) chk("final_reg", 32'(u_rf.regs_q[i]), 32'(m_rf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
